// File: rtl/vmx_pkg.sv
// vmx_pkg: shared command bit positions, FSM encoding and timeout scale for the array sequencer
package vmx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;
  localparam int CMD_VALID = 7;
  localparam int CMD_LAST = 6;
  localparam int CMD_ACC = 5;
  localparam int TIMEOUT_MULT = 4;
endpackage

// File: rtl/vmx_seq_counter.sv
// vmx_seq_counter: loadable saturating up-counter with a terminal-match flag
module vmx_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] match,
  output logic [W-1:0] count,
  output logic         hit
);
  assign hit = count == match;
  // load wins over increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (ena) count <= load ? load_val : (inc && count != '1) ? count + W'(1) : count;
endmodule

// File: rtl/vmx_array_sequencer.sv
// vmx_array_sequencer: feeds an operand stream into a PE array with per-beat commands and returns the final product
module vmx_array_sequencer
  import vmx_pkg::*;
#(
  parameter int ARRAY_SIZE     = 4,
  parameter int VECTORS_BITLEN = 16,
  parameter int COMMAND_BITLEN = 8,
  parameter int LEN_BITLEN     = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     ena,
  input  logic                                     start,
  input  logic [LEN_BITLEN-1:0]                    len,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  input  logic [VECTORS_BITLEN*ARRAY_SIZE-1:0]     s_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  output logic [VECTORS_BITLEN*ARRAY_SIZE-1:0]     arr_vectors,
  output logic [COMMAND_BITLEN*ARRAY_SIZE-1:0]     arr_command,
  input  logic [2*VECTORS_BITLEN*ARRAY_SIZE-1:0]   arr_product,
  input  logic                                     arr_valid,
  output logic [2*VECTORS_BITLEN*ARRAY_SIZE-1:0]   r_data,
  output logic                                     r_valid,
  input  logic                                     r_ready
);
  localparam logic [LEN_BITLEN-1:0] TMO_LAST = LEN_BITLEN'(TIMEOUT_MULT * ARRAY_SIZE - 1);
  state_t state, state_nx;
  logic [LEN_BITLEN-1:0] len_q, len_m1, beat_cnt, vld_cnt, tmo_cnt;
  logic beat_last, vld_last, tmo_hit, kick, beat_fire, vld_fire, complete, timeout;
  logic [COMMAND_BITLEN-1:0] lane;
  assign len_m1 = len_q - LEN_BITLEN'(1);
  assign kick = state == IDLE && start && len != '0;
  assign beat_fire = state == LOAD && s_valid;
  assign vld_fire = (state == LOAD || state == DRAIN) && arr_valid;
  assign complete = vld_fire && vld_last;
  assign timeout = state == DRAIN && tmo_hit && !complete;
  assign s_ready = state == LOAD;
  assign busy = state != IDLE;
  assign r_valid = state == OUT;
  vmx_seq_counter #(.W(LEN_BITLEN)) u_beat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(kick), .load_val('0),
    .inc(beat_fire), .match(len_m1), .count(beat_cnt), .hit(beat_last)
  );
  vmx_seq_counter #(.W(LEN_BITLEN)) u_vld (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(kick), .load_val('0),
    .inc(vld_fire && vld_cnt != len_q), .match(len_m1), .count(vld_cnt), .hit(vld_last)
  );
  vmx_seq_counter #(.W(LEN_BITLEN)) u_tmo (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load(kick), .load_val('0),
    .inc(state == DRAIN && tmo_cnt != TMO_LAST), .match(TMO_LAST), .count(tmo_cnt), .hit(tmo_hit)
  );
  // per-lane command: valid tag always, last on the final beat, accumulate after the first beat
  always_comb begin
    lane = '0;
    lane[CMD_VALID] = 1'b1;
    lane[CMD_LAST] = beat_last;
    lane[CMD_ACC] = beat_cnt != '0;
  end
  // state register, frozen while ena is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (ena) state <= state_nx;
  // next state: array completion takes priority over issuing and over the drain timeout
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = kick ? LOAD : IDLE;
      LOAD:  state_nx = complete ? OUT : (beat_fire && beat_last) ? DRAIN : LOAD;
      DRAIN: state_nx = complete ? OUT : timeout ? IDLE : DRAIN;
      OUT:   state_nx = r_ready ? IDLE : OUT;
    endcase
  end
  // datapath: array bus, result capture, done pulse and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len_q <= '0;
      done <= 1'b0;
      err <= 1'b0;
      arr_command <= '0;
      arr_vectors <= '0;
      r_data <= '0;
    end else if (ena) begin
      if (kick) len_q <= len;
      done <= (state == IDLE && start && len == '0) || timeout || (state == OUT && r_ready);
      err <= (state == IDLE && start) ? 1'b0 : timeout ? 1'b1 : err;
      arr_command <= beat_fire ? {ARRAY_SIZE{lane}} : '0;
      if (beat_fire) arr_vectors <= s_data;
      if (complete) r_data <= arr_product;
    end
endmodule
